switch_cfg_loader: RTL

//  Serial configuration loader feeding the 5x4 switch-box matrix. Hunts for a sync

---
 rtl/switch_cfg_pkg.sv | 52 +++++
 rtl/switch_cfg_loader_if.sv | 23 ++
 rtl/cfg_field_deser.sv | 35 +++
 rtl/switch_cfg_loader.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/switch_cfg_pkg.sv
// rtl/switch_cfg_pkg.sv - shared constants, types and range rule for the switch config loader
package switch_cfg_pkg;

    localparam int N_TB      = 5;
    localparam int N_LR      = 4;
    localparam int ENTRY_W   = 6;
    localparam int N_ENTRIES = 2 * N_TB + 2 * N_LR;
    localparam int CFG_W     = N_ENTRIES * ENTRY_W;

    localparam logic [7:0] SYNC_WORD = 8'hA5;

    // Source side codes carried in entry bits [2:0]
    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    // Entry index offsets into the route set
    localparam int TOP_BASE   = 0;
    localparam int BOT_BASE   = 5;
    localparam int LEFT_BASE  = 10;
    localparam int RIGHT_BASE = 14;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_CHK   = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } load_state_t;

    // True when an entry names a source wire that does not exist on its side
    function automatic logic entry_out_of_range(input logic [ENTRY_W-1:0] e);
        logic [2:0] side;
        logic [2:0] idx;
        logic       bad;
        side = e[2:0];
        idx  = e[5:3];
        case (side)
            SIDE_NONE:               bad = 1'b0;
            SIDE_TOP, SIDE_BOTTOM:   bad = (idx >= 3'(N_TB));
            SIDE_RIGHT, SIDE_LEFT:   bad = (idx >= 3'(N_LR));
            default:                 bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/switch_cfg_loader_if.sv
// rtl/switch_cfg_loader_if.sv - serial config stream handshake between source and loader
interface switch_cfg_loader_if;

    logic cfg_valid;
    logic cfg_bit;
    logic cfg_ready;
    logic cfg_abort;

    modport master (
        output cfg_valid,
        output cfg_bit,
        output cfg_abort,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_bit,
        input  cfg_abort,
        output cfg_ready
    );

endinterface

// File: rtl/cfg_field_deser.sv
// rtl/cfg_field_deser.sv - 6-bit serial-in field deserialiser with completion strobe
module cfg_field_deser
    import switch_cfg_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_in,
    output logic [ENTRY_W-1:0] field,
    output logic               field_done
);

    logic [ENTRY_W-2:0] sr;
    logic [2:0]         bit_cnt;

    // The completed field includes the bit arriving this cycle so the parent can use it on the same edge
    assign field      = {sr, bit_in};
    assign field_done = shift_en & (bit_cnt == 3'(ENTRY_W - 1));

    // Shift register and bit counter; counter wraps after each full field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            sr      <= field[ENTRY_W-2:0];
            bit_cnt <= field_done ? 3'd0 : bit_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/switch_cfg_loader.sv
// rtl/switch_cfg_loader.sv - sync hunt, route deserialise, check and atomic commit to the switch matrix
module switch_cfg_loader
    import switch_cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    switch_cfg_loader_if.slave   cfg,
    output logic [CFG_W-1:0]     cfg_out,
    output logic                 cfg_done,
    output logic                 cfg_err,
    output logic [1:0]           err_code,
    output logic                 busy
);

    load_state_t        state;
    load_state_t        state_nxt;

    logic [7:0]         sync_win;
    logic               xfer;
    logic               sync_hit;
    logic [4:0]         entry_idx;
    logic [ENTRY_W-1:0] chk_acc;
    logic [ENTRY_W-1:0] rx_chk;
    logic               range_err;
    logic [CFG_W-1:0]   shadow;

    logic               deser_clr;
    logic               deser_en;
    logic [ENTRY_W-1:0] field;
    logic               field_done;

    // Abort wins over a same-cycle transfer, so the bit is dropped rather than consumed
    assign xfer      = cfg.cfg_valid & cfg.cfg_ready & ~cfg.cfg_abort;
    assign sync_hit  = (state == HUNT) & xfer & ({sync_win[6:0], cfg.cfg_bit} == SYNC_WORD);
    assign deser_en  = xfer & ((state == LOAD) | (state == CHECK));
    assign deser_clr = sync_hit | cfg.cfg_abort;

    cfg_field_deser u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (deser_clr),
        .shift_en   (deser_en),
        .bit_in     (cfg.cfg_bit),
        .field      (field),
        .field_done (field_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort returns to sync hunt from anywhere
    always_comb begin
        state_nxt = state;
        if (cfg.cfg_abort) begin
            state_nxt = HUNT;
        end else begin
            case (state)
                HUNT:    if (sync_hit) state_nxt = LOAD;
                LOAD:    if (deser_en && field_done && entry_idx == 5'(N_ENTRIES - 1)) state_nxt = CHECK;
                CHECK:   if (deser_en && field_done) state_nxt = COMMIT;
                COMMIT:  state_nxt = HUNT;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // State-decoded outputs: only the single commit cycle refuses bits
    always_comb begin
        cfg.cfg_ready = 1'b1;
        busy          = 1'b0;
        if (state == COMMIT) cfg.cfg_ready = 1'b0;
        if (state != HUNT)   busy          = 1'b1;
    end

    // Sync window; cleared on a match so a new hunt never reuses bits of the previous frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_win <= '0;
        end else if (cfg.cfg_abort || sync_hit) begin
            sync_win <= '0;
        end else if (state == HUNT && xfer) begin
            sync_win <= {sync_win[6:0], cfg.cfg_bit};
        end
    end

    // Entry capture into the shadow store with running checksum and sticky range flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_idx <= '0;
            chk_acc   <= '0;
            range_err <= 1'b0;
            shadow    <= '0;
        end else if (sync_hit) begin
            entry_idx <= '0;
            chk_acc   <= '0;
            range_err <= 1'b0;
        end else if (state == LOAD && deser_en && field_done) begin
            shadow[entry_idx*ENTRY_W +: ENTRY_W] <= field;
            chk_acc   <= chk_acc ^ field;
            range_err <= range_err | entry_out_of_range(field);
            entry_idx <= entry_idx + 5'd1;
        end
    end

    // Received checksum field
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_chk <= '0;
        end else if (state == CHECK && deser_en && field_done) begin
            rx_chk <= field;
        end
    end

    // Commit decision: range error outranks checksum error; only a clean frame reaches cfg_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_out  <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            if (state == COMMIT && !cfg.cfg_abort) begin
                if (range_err) begin
                    cfg_err  <= 1'b1;
                    err_code <= ERR_RANGE;
                end else if (rx_chk != chk_acc) begin
                    cfg_err  <= 1'b1;
                    err_code <= ERR_CHK;
                end else begin
                    cfg_out  <= shadow;
                    cfg_done <= 1'b1;
                end
            end
        end
    end

endmodule
